// File: rtl/eth_idma_pkg.sv
// Shared types for the Ethernet iDMA request arbiter.
// Request/response bundles, direction tag and arbiter states.
package eth_idma_pkg;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] length;
  } idma_req_t;

  typedef struct packed {
    logic        error;
    logic [3:0]  cause;
    logic [31:0] burst_addr;
  } idma_rsp_t;

  typedef enum logic {
    ETH_DIR_TX = 1'b0,
    ETH_DIR_RX = 1'b1
  } eth_dir_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_v3.sv
// Synchronous FIFO, port-compatible with common_cells fifo_v3.
// Optional fall-through, flush, power-of-two or arbitrary depth.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0],
  parameter int unsigned ADDR_DEPTH   =
    (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  dtype                  data_i,
  input  logic                  push_i,
  output dtype                  data_o,
  input  logic                  pop_i
);

  localparam int unsigned FifoDepth =
    (DEPTH > 0) ? DEPTH : 1;
  localparam int unsigned CntW = ADDR_DEPTH + 1;

  dtype                  mem_q [FifoDepth];
  logic [ADDR_DEPTH-1:0] rd_q;
  logic [ADDR_DEPTH-1:0] wr_q;
  logic [CntW-1:0]       cnt_q;
  logic                  bypass;
  logic                  do_push;
  logic                  do_pop;
  logic                  tm_unused;

  assign tm_unused = testmode_i;

  assign full_o  = (cnt_q == CntW'(FifoDepth));
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign bypass  = FALL_THROUGH &&
                   (cnt_q == '0) && push_i;
  assign empty_o = (cnt_q == '0) && !bypass;
  assign data_o  = bypass ? data_i : mem_q[rd_q];

  assign do_push = push_i && !full_o &&
                   !(bypass && pop_i);
  assign do_pop  = pop_i && !empty_o && !bypass;

  // Pointer, occupancy and storage update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++)
        mem_q[i] <= dtype'(0);
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= data_i;
        wr_q <= (wr_q == ADDR_DEPTH'(FifoDepth - 1)) ?
                '0 : wr_q + 1'b1;
      end
      if (do_pop)
        rd_q <= (rd_q == ADDR_DEPTH'(FifoDepth - 1)) ?
                '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CntW'(do_push) - CntW'(do_pop);
    end
  end

endmodule

// File: rtl/eth_idma_req_arb.sv
// Round-robin TX/RX arbiter onto one iDMA backend.
// In-order tag FIFO routes each response to its requester.
module eth_idma_req_arb #(
  parameter int unsigned NumOutstanding = 4,
  parameter type idma_req_t = eth_idma_pkg::idma_req_t,
  parameter type idma_rsp_t = eth_idma_pkg::idma_rsp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  idma_req_t tx_req_i,
  input  logic      tx_req_valid_i,
  output logic      tx_req_ready_o,
  output idma_rsp_t tx_rsp_o,
  output logic      tx_rsp_valid_o,
  input  logic      tx_rsp_ready_i,
  input  idma_req_t rx_req_i,
  input  logic      rx_req_valid_i,
  output logic      rx_req_ready_o,
  output idma_rsp_t rx_rsp_o,
  output logic      rx_rsp_valid_o,
  input  logic      rx_rsp_ready_i,
  output idma_req_t be_req_o,
  output logic      be_req_valid_o,
  input  logic      be_req_ready_i,
  input  idma_rsp_t be_rsp_i,
  input  logic      be_rsp_valid_i,
  output logic      be_rsp_ready_o,
  output logic      busy_o,
  output logic      err_o
);

  import eth_idma_pkg::*;

  localparam int unsigned UsageW =
    $clog2(NumOutstanding);

  arb_state_e  state_q;
  eth_dir_e    lock_dir_q;
  eth_dir_e    last_dir_q;
  eth_dir_e    grant_dir;
  eth_dir_e    head_dir;
  logic        grant_valid;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic        err_q;
  logic [UsageW-1:0] usage_unused;

  // Pick the requester that owns the backend this cycle
  always_comb begin
    grant_valid = 1'b0;
    grant_dir   = ETH_DIR_TX;
    if (state_q == LOCKED) begin
      grant_valid = 1'b1;
      grant_dir   = lock_dir_q;
    end else if (!full) begin
      unique case (1'b1)
        tx_req_valid_i && rx_req_valid_i: begin
          grant_valid = 1'b1;
          grant_dir   = (last_dir_q == ETH_DIR_TX) ?
                        ETH_DIR_RX : ETH_DIR_TX;
        end
        rx_req_valid_i && !tx_req_valid_i: begin
          grant_valid = 1'b1;
          grant_dir   = ETH_DIR_RX;
        end
        tx_req_valid_i && !rx_req_valid_i: begin
          grant_valid = 1'b1;
          grant_dir   = ETH_DIR_TX;
        end
        default: ;
      endcase
    end
  end

  assign be_req_o = (grant_dir == ETH_DIR_RX) ?
                    rx_req_i : tx_req_i;
  assign be_req_valid_o = grant_valid;
  assign tx_req_ready_o = grant_valid &&
    (grant_dir == ETH_DIR_TX) && be_req_ready_i;
  assign rx_req_ready_o = grant_valid &&
    (grant_dir == ETH_DIR_RX) && be_req_ready_i;
  assign push = grant_valid && be_req_ready_i;

  // Hold a stalled grant; rotate priority on handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lock_dir_q <= ETH_DIR_TX;
      last_dir_q <= ETH_DIR_TX;
    end else if (push) begin
      state_q    <= IDLE;
      last_dir_q <= grant_dir;
    end else if (grant_valid) begin
      state_q    <= LOCKED;
      lock_dir_q <= grant_dir;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (NumOutstanding),
    .dtype        (eth_dir_e)
  ) i_tag_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (full),
    .empty_o    (empty),
    .usage_o    (usage_unused),
    .data_i     (grant_dir),
    .push_i     (push),
    .data_o     (head_dir),
    .pop_i      (pop)
  );

  assign tx_rsp_o = be_rsp_i;
  assign rx_rsp_o = be_rsp_i;

  // Steer the backend response to the oldest tag's owner
  always_comb begin
    tx_rsp_valid_o = 1'b0;
    rx_rsp_valid_o = 1'b0;
    be_rsp_ready_o = 1'b1;
    if (!empty) begin
      if (head_dir == ETH_DIR_RX) begin
        rx_rsp_valid_o = be_rsp_valid_i;
        be_rsp_ready_o = rx_rsp_ready_i;
      end else begin
        tx_rsp_valid_o = be_rsp_valid_i;
        be_rsp_ready_o = tx_rsp_ready_i;
      end
    end
  end

  assign pop = be_rsp_valid_i && be_rsp_ready_o &&
               !empty;

  // Orphan responses are dropped but flagged until reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      err_q <= 1'b0;
    else if (be_rsp_valid_i && empty)
      err_q <= 1'b1;
  end

  assign err_o  = err_q;
  assign busy_o = !empty;

endmodule
